// File: rtl/alarm_bank_pkg.sv
// alarm_bank_pkg: shared BCD time type, ring FSM states and time validation.
package alarm_bank_pkg;
  typedef struct packed {
    logic [3:0] ms_hr;
    logic [3:0] ls_hr;
    logic [3:0] ms_min;
    logic [3:0] ls_min;
  } bcd_time_t;
  typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} alarm_state_e;
  function automatic logic is_valid_bcd_time(bcd_time_t t);
    return (t.ms_hr <= 4'd2) && (t.ls_hr <= 4'd9) && ((t.ms_hr != 4'd2) || (t.ls_hr <= 4'd3)) &&
           (t.ms_min <= 4'd5) && (t.ls_min <= 4'd9);
  endfunction
endpackage

// File: rtl/alarm_bank_if.sv
// alarm_bank_if: load, time, control and status signals of the alarm bank.
interface alarm_bank_if #(parameter int NUM_ALARMS = 4);
  localparam int SLOT_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
  logic                  load_new_a;
  logic [SLOT_W-1:0]     load_slot;
  logic [3:0]            new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min;
  logic [NUM_ALARMS-1:0] slot_en;
  logic [3:0]            cur_ms_hr, cur_ls_hr, cur_ms_min, cur_ls_min;
  logic                  minute_tick, stop_alarm, snooze;
  logic [SLOT_W-1:0]     rd_slot;
  logic [3:0]            alarm_time_ms_hr, alarm_time_ls_hr, alarm_time_ms_min, alarm_time_ls_min;
  logic                  sound_alarm;
  logic [SLOT_W-1:0]     ring_slot;
  logic                  load_err;
  modport master (
    output load_new_a, load_slot, new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min,
           slot_en, cur_ms_hr, cur_ls_hr, cur_ms_min, cur_ls_min, minute_tick, stop_alarm, snooze, rd_slot,
    input  alarm_time_ms_hr, alarm_time_ls_hr, alarm_time_ms_min, alarm_time_ls_min, sound_alarm, ring_slot,
           load_err
  );
  modport slave (
    input  load_new_a, load_slot, new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min,
           slot_en, cur_ms_hr, cur_ls_hr, cur_ms_min, cur_ls_min, minute_tick, stop_alarm, snooze, rd_slot,
    output alarm_time_ms_hr, alarm_time_ls_hr, alarm_time_ms_min, alarm_time_ls_min, sound_alarm, ring_slot,
           load_err
  );
endinterface

// File: rtl/alarm_bank_slot.sv
// alarm_slot: one stored alarm time with write enable and per-minute match.
module alarm_slot
  import alarm_bank_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      we_i,
  input  logic      en_i,
  input  logic      tick_i,
  input  bcd_time_t wdata_i,
  input  bcd_time_t cur_i,
  output bcd_time_t time_o,
  output logic      hit_o
);
  bcd_time_t time_q, time_d;
  assign time_d = we_i ? wdata_i : time_q;
  always_ff @(posedge clock or posedge reset)
    if (reset) time_q <= '0;
    else       time_q <= time_d;
  assign time_o = time_q;
  assign hit_o  = tick_i & en_i & (time_q == cur_i);
endmodule

// File: rtl/alarm_bank.sv
// alarm_bank: multi-slot alarm store with ring/timeout FSM; snooze built only with ALARM_BANK_SNOOZE_EN.
module alarm_bank
  import alarm_bank_pkg::*;
#(
  parameter int NUM_ALARMS       = 4,
  parameter int SNOOZE_MIN       = 5,
  parameter int RING_TIMEOUT_MIN = 10
) (
  input logic        clock,
  input logic        reset,
  alarm_bank_if.slave bus
);
  localparam int SLOT_W  = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
  localparam int CNT_MAX = (SNOOZE_MIN > RING_TIMEOUT_MIN) ? SNOOZE_MIN : RING_TIMEOUT_MIN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  bcd_time_t new_t, cur_t, rd_t;
  bcd_time_t slot_t [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] hit;
  logic load_ok, hit_any, ring_en;
  logic [SLOT_W-1:0] win;
  alarm_state_e state_q, state_d;
  logic [SLOT_W-1:0] ring_slot_q, ring_slot_d;
  logic [CNT_W-1:0] ring_cnt_q, ring_cnt_d;
  logic sound_q, load_err_q;
  assign new_t   = {bus.new_alarm_ms_hr, bus.new_alarm_ls_hr, bus.new_alarm_ms_min, bus.new_alarm_ls_min};
  assign cur_t   = {bus.cur_ms_hr, bus.cur_ls_hr, bus.cur_ms_min, bus.cur_ls_min};
  assign load_ok = is_valid_bcd_time(new_t) && (32'(bus.load_slot) < NUM_ALARMS);
  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_slot
    alarm_slot u_slot (
      .clock  (clock),
      .reset  (reset),
      .we_i   (bus.load_new_a && load_ok && (32'(bus.load_slot) == i)),
      .en_i   (bus.slot_en[i]),
      .tick_i (bus.minute_tick),
      .wdata_i(new_t),
      .cur_i  (cur_t),
      .time_o (slot_t[i]),
      .hit_o  (hit[i])
    );
  end
  assign rd_t = (32'(bus.rd_slot) < NUM_ALARMS) ? slot_t[bus.rd_slot] : '0;
  assign {bus.alarm_time_ms_hr, bus.alarm_time_ls_hr, bus.alarm_time_ms_min, bus.alarm_time_ls_min} = rd_t;
  // Scan downward so the lowest-index hit is the last one written.
  always_comb begin
    hit_any = 1'b0;
    win     = '0;
    for (int k = NUM_ALARMS - 1; k >= 0; k--)
      if (hit[k]) begin
        hit_any = 1'b1;
        win     = SLOT_W'(k);
      end
  end
  assign ring_en = bus.slot_en[ring_slot_q];
`ifdef ALARM_BANK_SNOOZE_EN
  logic [CNT_W-1:0] snz_cnt_q, snz_cnt_d;
  always_ff @(posedge clock or posedge reset)
    if (reset) snz_cnt_q <= '0;
    else       snz_cnt_q <= snz_cnt_d;
`else
  logic unused_snooze;
  assign unused_snooze = bus.snooze;
`endif
  always_comb begin
    state_d     = state_q;
    ring_slot_d = ring_slot_q;
    ring_cnt_d  = ring_cnt_q;
`ifdef ALARM_BANK_SNOOZE_EN
    snz_cnt_d   = snz_cnt_q;
`endif
    case (state_q)
      IDLE:
        if (hit_any) begin
          state_d     = RINGING;
          ring_slot_d = win;
          ring_cnt_d  = '0;
        end
      RINGING:
        if (bus.stop_alarm || !ring_en) state_d = IDLE;
`ifdef ALARM_BANK_SNOOZE_EN
        else if (bus.snooze) begin
          state_d   = SNOOZE;
          snz_cnt_d = CNT_W'(SNOOZE_MIN);
        end
`endif
        else if (bus.minute_tick) begin
          ring_cnt_d = ring_cnt_q + 1'b1;
          state_d    = (ring_cnt_d == CNT_W'(RING_TIMEOUT_MIN)) ? IDLE : RINGING;
        end
`ifdef ALARM_BANK_SNOOZE_EN
      SNOOZE:
        if (bus.stop_alarm || !ring_en) state_d = IDLE;
        else if (bus.minute_tick) begin
          snz_cnt_d = snz_cnt_q - 1'b1;
          if (snz_cnt_d == '0) begin
            state_d    = RINGING;
            ring_cnt_d = '0;
          end
        end
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q     <= IDLE;
      ring_slot_q <= '0;
      ring_cnt_q  <= '0;
      sound_q     <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ring_slot_q <= ring_slot_d;
      ring_cnt_q  <= ring_cnt_d;
      sound_q     <= (state_d == RINGING);
      load_err_q  <= bus.load_new_a && !load_ok;
    end
  assign bus.sound_alarm = sound_q;
  assign bus.ring_slot   = ring_slot_q;
  assign bus.load_err    = load_err_q;
endmodule

// File: tb/tb_alarm_bank.sv
// tb_alarm_bank: directed and random stimulus against a behavioural alarm clock model.
module tb_alarm_bank;
  localparam int N = 4, SNZ = 5, RTO = 10;
`ifdef ALARM_BANK_SNOOZE_EN
  localparam bit SNZ_EN = 1'b1;
`else
  localparam bit SNZ_EN = 1'b0;
`endif
  logic clock = 1'b0, reset = 1'b1;
  always #5 clock = ~clock;
  alarm_bank_if #(.NUM_ALARMS(N)) bus ();
  alarm_bank #(.NUM_ALARMS(N), .SNOOZE_MIN(SNZ), .RING_TIMEOUT_MIN(RTO)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );
  logic [15:0] m_time [N];
  int st, m_rs, rc, sc, n_chk, n_fail;
  bit m_err;
  function automatic int mins(logic [15:0] t);
    return (int'(t[15:12]) * 10 + int'(t[11:8])) * 60 + int'(t[7:4]) * 10 + int'(t[3:0]);
  endfunction
  function automatic bit valid_time(logic [15:0] t);
    int h = int'(t[15:12]) * 10 + int'(t[11:8]);
    return t[15:12] <= 2 && t[11:8] <= 9 && t[7:4] <= 5 && t[3:0] <= 9 && h < 24;
  endfunction
  function automatic logic [15:0] to_bcd(int h, int m);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction
  task automatic model_reset();
    st = 0; m_rs = 0; rc = 0; sc = 0; m_err = 0;
    for (int i = 0; i < N; i++) m_time[i] = '0;
  endtask
  task automatic model_step();
    logic [15:0] nt, ct;
    int w = -1;
    nt = {bus.new_alarm_ms_hr, bus.new_alarm_ls_hr, bus.new_alarm_ms_min, bus.new_alarm_ls_min};
    ct = {bus.cur_ms_hr, bus.cur_ls_hr, bus.cur_ms_min, bus.cur_ls_min};
    if (bus.minute_tick)
      for (int i = N - 1; i >= 0; i--) if (bus.slot_en[i] && mins(m_time[i]) == mins(ct)) w = i;
    m_err = bus.load_new_a && !(valid_time(nt) && int'(bus.load_slot) < N);
    if (bus.load_new_a && !m_err) m_time[bus.load_slot] = nt;
    if (st == 0) begin
      if (w >= 0) begin st = 1; m_rs = w; rc = 0; end
    end else if (bus.stop_alarm || !bus.slot_en[m_rs]) st = 0;
    else if (st == 1) begin
      if (SNZ_EN && bus.snooze) begin st = 2; sc = SNZ; end
      else if (bus.minute_tick) begin rc++; if (rc == RTO) st = 0; end
    end else if (bus.minute_tick) begin
      sc--;
      if (sc == 0) begin st = 1; rc = 0; end
    end
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_outs();
    chk("sound_alarm", 16'(bus.sound_alarm), 16'(st == 1));
    chk("ring_slot", 16'(bus.ring_slot), 16'(m_rs));
    chk("load_err", 16'(bus.load_err), 16'(m_err));
    chk("alarm_time", {bus.alarm_time_ms_hr, bus.alarm_time_ls_hr, bus.alarm_time_ms_min, bus.alarm_time_ls_min},
        m_time[bus.rd_slot]);
  endtask
  task automatic cycle();
    model_step();
    @(posedge clock); #1;
    bus.load_new_a = 0; bus.minute_tick = 0; bus.stop_alarm = 0; bus.snooze = 0;
    check_outs();
  endtask
  task automatic load(input int s, input logic [15:0] t);
    bus.load_new_a = 1; bus.load_slot = 2'(s);
    {bus.new_alarm_ms_hr, bus.new_alarm_ls_hr, bus.new_alarm_ms_min, bus.new_alarm_ls_min} = t;
    cycle();
  endtask
  task automatic tick(input logic [15:0] t);
    {bus.cur_ms_hr, bus.cur_ls_hr, bus.cur_ms_min, bus.cur_ls_min} = t;
    bus.minute_tick = 1;
    cycle();
  endtask
  task automatic check_all_slots();
    for (int s = 0; s < N; s++) begin bus.rd_slot = 2'(s); #1; check_outs(); end
  endtask
  initial begin
    n_chk = 0; n_fail = 0;
    bus.load_new_a = 0; bus.load_slot = 0; bus.slot_en = 0; bus.minute_tick = 0;
    bus.stop_alarm = 0; bus.snooze = 0; bus.rd_slot = 0;
    {bus.new_alarm_ms_hr, bus.new_alarm_ls_hr, bus.new_alarm_ms_min, bus.new_alarm_ls_min} = 16'h0;
    {bus.cur_ms_hr, bus.cur_ls_hr, bus.cur_ms_min, bus.cur_ls_min} = 16'h0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_all_slots();
    reset = 0;
    bus.rd_slot = 2;
    load(2, 16'h0730);
    cycle();
    load(0, 16'h2400);
    load(1, 16'h1260);
    load(3, 16'h1970);
    cycle();
    check_all_slots();
    load(1, 16'h0600);
    load(3, 16'h0600);
    bus.slot_en = 4'b1010;
    tick(16'h0600);
    bus.stop_alarm = 1; cycle();
    tick(16'h0600);
    bus.snooze = 1; cycle();
    for (int i = 0; i < SNZ; i++) begin tick(16'h0601); cycle(); end
    bus.stop_alarm = 1; cycle();
    tick(16'h0600);
    repeat (RTO) tick(16'h0700);
    cycle();
    tick(16'h0600);
    load(1, 16'h0900);
    tick(16'h0600);
    bus.slot_en = 4'b1000; cycle();
    bus.slot_en = 4'b1010;
    tick(16'h0600);
    #2 reset = 1;
    #1 model_reset();
    check_all_slots();
    @(posedge clock); #1;
    reset = 0;
    load(0, 16'h1234);
    bus.slot_en = 4'b0001;
    tick(16'h1234);
    bus.stop_alarm = 1; bus.snooze = 1; cycle();
    repeat (600) begin
      bus.load_new_a = ($urandom_range(0, 3) == 0);
      bus.load_slot = 2'($urandom_range(0, N - 1));
      bus.new_alarm_ms_hr = 4'($urandom_range(0, 3));
      bus.new_alarm_ls_hr = 4'($urandom_range(0, 10));
      bus.new_alarm_ms_min = 4'($urandom_range(0, 6));
      bus.new_alarm_ls_min = 4'($urandom_range(0, 10));
      if ($urandom_range(0, 19) == 0) bus.slot_en = 4'($urandom);
      if ($urandom_range(0, 2) == 0)
        {bus.cur_ms_hr, bus.cur_ls_hr, bus.cur_ms_min, bus.cur_ls_min} = m_time[$urandom_range(0, N - 1)];
      else
        {bus.cur_ms_hr, bus.cur_ls_hr, bus.cur_ms_min, bus.cur_ls_min} =
          to_bcd($urandom_range(0, 23), $urandom_range(0, 59));
      bus.minute_tick = 1'($urandom_range(0, 1));
      bus.stop_alarm = ($urandom_range(0, 24) == 0);
      bus.snooze = ($urandom_range(0, 7) == 0);
      bus.rd_slot = 2'($urandom_range(0, N - 1));
      cycle();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
